// File: rtl/draw_arbiter_if.sv
// Draw-port bundle between the map/sprite engines, the arbiter and the VGA adapter.
// Latency: none (wires only); the arbiter registers every output it drives here.
// Backpressure: none; engines watch grant_map/grant_spr, and pixels sent without a grant are dropped.
// Optional macro ARB_STATS_EN adds the map_passes/spr_passes counters to the bundle.
interface draw_arbiter_if #(
    parameter int COLOUR_W = 3
);
    logic                frame_tick;

    logic                map_req;
    logic                map_valid;
    logic [8:0]          map_x;
    logic [7:0]          map_y;
    logic [COLOUR_W-1:0] map_colour;
    logic                map_done;

    logic                spr_req;
    logic                spr_valid;
    logic [8:0]          spr_x;
    logic [7:0]          spr_y;
    logic [COLOUR_W-1:0] spr_colour;
    logic                spr_done;

    logic                grant_map;
    logic                grant_spr;
    logic [8:0]          vga_x;
    logic [7:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                done_redraw;
    logic                timeout_err;

`ifdef ARB_STATS_EN
    logic [15:0]         map_passes;
    logic [15:0]         spr_passes;
`endif

    // Engine/FSM side: drives requests and pixels, observes grants and the VGA stream.
    modport master (
        output frame_tick,
        output map_req, map_valid, map_x, map_y, map_colour, map_done,
        output spr_req, spr_valid, spr_x, spr_y, spr_colour, spr_done,
        input  grant_map, grant_spr,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  done_redraw, timeout_err
`ifdef ARB_STATS_EN
        , input map_passes, spr_passes
`endif
    );

    // Arbiter side: consumes requests and pixels, owns grants and the VGA stream.
    modport slave (
        input  frame_tick,
        input  map_req, map_valid, map_x, map_y, map_colour, map_done,
        input  spr_req, spr_valid, spr_x, spr_y, spr_colour, spr_done,
        output grant_map, grant_spr,
        output vga_x, vga_y, vga_colour, vga_plot,
        output done_redraw, timeout_err
`ifdef ARB_STATS_EN
        , output map_passes, spr_passes
`endif
    );
endinterface

// File: rtl/draw_arbiter.sv
// Shares the VGA write port between the map redraw engine and the sprite engine.
// Latency: grants one cycle after the request is seen; each pixel reaches vga_* one cycle after it is presented.
// Backpressure: none; only the granted engine's pixels are written, and the others are dropped.
// Optional macro ARB_STATS_EN adds the map_passes/spr_passes completed-pass counters.
module draw_arbiter #(
    parameter int COLOUR_W       = 3,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic          clock,
    input  logic          reset,
    draw_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        SPR  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state;
    logic                grantMap;
    logic                grantSpr;
    logic                doneRedraw;
    logic                timeoutErr;
    logic                tickPending;
    logic                sprDirty;
    logic [CNT_W-1:0]    holdCnt;

    logic                vgaPlot;
    logic [8:0]          vgaX;
    logic [7:0]          vgaY;
    logic [COLOUR_W-1:0] vgaColour;

    logic                startMap;
    logic                startSpr;
    logic                holdExpired;

    // Pick the next owner while idle: a sprite owed a redraw after a map pass comes first,
    // then a fresh map request, then a frame-paced sprite redraw.
    always_comb begin
        startMap = 1'b0;
        startSpr = 1'b0;
        if (state == IDLE) begin
            if (sprDirty && bus.spr_req) begin
                startSpr = 1'b1;
            end else if (bus.map_req && !doneRedraw) begin
                startMap = 1'b1;
            end else if (bus.spr_req && tickPending) begin
                startSpr = 1'b1;
            end
        end
    end

    assign holdExpired = (holdCnt == HOLD_LAST);

    // Ownership FSM with registered grants, handshake flags and the hold-time watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grantMap    <= 1'b0;
            grantSpr    <= 1'b0;
            doneRedraw  <= 1'b0;
            timeoutErr  <= 1'b0;
            tickPending <= 1'b0;
            sprDirty    <= 1'b0;
            holdCnt     <= '0;
        end else begin
            // A tick arriving in the SPR entry cycle belongs to the next frame, so the
            // clear below is skipped when frame_tick is high.
            if (bus.frame_tick) begin
                tickPending <= 1'b1;
            end

            // done_redraw is a level the game FSM waits on; it falls only once drawMap drops,
            // so a held drawMap cannot restart the map engine.
            if ((state == MAP) && bus.map_done) begin
                doneRedraw <= 1'b1;
            end else if (!bus.map_req) begin
                doneRedraw <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (startSpr) begin
                        state    <= SPR;
                        grantSpr <= 1'b1;
                        holdCnt  <= '0;
                        sprDirty <= 1'b0;
                        if (!bus.frame_tick) begin
                            tickPending <= 1'b0;
                        end
                    end else if (startMap) begin
                        state    <= MAP;
                        grantMap <= 1'b1;
                        holdCnt  <= '0;
                    end
                end

                MAP: begin
                    // A done on the last allowed cycle still counts as a clean finish.
                    if (bus.map_done) begin
                        state    <= GAP;
                        grantMap <= 1'b0;
                        sprDirty <= 1'b1;
                    end else if (holdExpired) begin
                        state      <= GAP;
                        grantMap   <= 1'b0;
                        timeoutErr <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end

                SPR: begin
                    if (bus.spr_done) begin
                        state    <= GAP;
                        grantSpr <= 1'b0;
                    end else if (holdExpired) begin
                        state      <= GAP;
                        grantSpr   <= 1'b0;
                        timeoutErr <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end

                GAP: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    grantMap <= 1'b0;
                    grantSpr <= 1'b0;
                end
            endcase
        end
    end

    // Pixel register: forward the current owner's pixel and hold the coordinates between writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            vgaPlot   <= 1'b0;
            vgaX      <= '0;
            vgaY      <= '0;
            vgaColour <= '0;
        end else if (grantMap && bus.map_valid) begin
            vgaPlot   <= 1'b1;
            vgaX      <= bus.map_x;
            vgaY      <= bus.map_y;
            vgaColour <= bus.map_colour;
        end else if (grantSpr && bus.spr_valid) begin
            vgaPlot   <= 1'b1;
            vgaX      <= bus.spr_x;
            vgaY      <= bus.spr_y;
            vgaColour <= bus.spr_colour;
        end else begin
            vgaPlot <= 1'b0;
        end
    end

    assign bus.grant_map   = grantMap;
    assign bus.grant_spr   = grantSpr;
    assign bus.vga_plot    = vgaPlot;
    assign bus.vga_x       = vgaX;
    assign bus.vga_y       = vgaY;
    assign bus.vga_colour  = vgaColour;
    assign bus.done_redraw = doneRedraw;
    assign bus.timeout_err = timeoutErr;

`ifdef ARB_STATS_EN
    logic [15:0] mapPasses;
    logic [15:0] sprPasses;

    // Count passes that ended with their done pulse; watchdog aborts are not counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            mapPasses <= '0;
            sprPasses <= '0;
        end else begin
            if ((state == MAP) && bus.map_done) begin
                mapPasses <= mapPasses + 16'd1;
            end
            if ((state == SPR) && bus.spr_done) begin
                sprPasses <= sprPasses + 16'd1;
            end
        end
    end

    assign bus.map_passes = mapPasses;
    assign bus.spr_passes = sprPasses;
`endif

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Sequences and shares the single VGA adapter write port between the map redraw engine and the sprite engine.
- The map engine is started by the game-state FSM's drawMap level. When a map pass completes, this block returns the done-redraw level that the FSM waits on.
- After every map pass, the sprite is forced to redraw so it is never left erased under new background.
- Sits between the two draw engines and the VGA adapter.

Parameters:
- COLOUR_W, 3, colour bits per pixel.
- TIMEOUT_CYCLES, 131072, maximum cycles one owner may hold the port before forced abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per display frame.
- map_req  in  1  level; the game FSM's drawMap.
- map_valid  in  1  map pixel present.
- map_x  in  9  map pixel X.
- map_y  in  8  map pixel Y.
- map_colour  in  COLOUR_W  map pixel colour.
- map_done  in  1  pulse; map pass finished.
- spr_req  in  1  level; sprite engine wants to draw.
- spr_valid  in  1  sprite pixel present.
- spr_x  in  9  sprite pixel X.
- spr_y  in  8  sprite pixel Y.
- spr_colour  in  COLOUR_W  sprite pixel colour.
- spr_done  in  1  pulse; sprite pass finished.
- grant_map  out  1  map engine owns the port.
- grant_spr  out  1  sprite engine owns the port.
- vga_x  out  9  registered pixel X.
- vga_y  out  8  registered pixel Y.
- vga_colour  out  COLOUR_W  registered pixel colour.
- vga_plot  out  1  registered write enable.
- done_redraw  out  1  level to the game FSM.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset: all outputs 0; state IDLE; tick_pending=0; spr_dirty=0; timeout counter=0. Reset asserted mid-pass aborts immediately, with no further vga_plot.
- States: IDLE, MAP, SPR, GAP. grant_map=1 only in MAP; grant_spr=1 only in SPR. Grants are registered and never both 1.
- IDLE transitions:
  - spr_dirty && spr_req -> SPR (post-map priority).
  - Else map_req && !done_redraw -> MAP.
  - Else spr_req && tick_pending -> SPR.
  - Else stay.
- MAP:
  - map_done -> GAP; set spr_dirty; set done_redraw.
  - Else timeout -> GAP with timeout_err=1.
- SPR:
  - Entry clears tick_pending and spr_dirty.
  - spr_done -> GAP.
  - Else timeout -> GAP with timeout_err=1.
- GAP: exactly one cycle with no grant, then IDLE.
- tick_pending: set by frame_tick in any state. If frame_tick arrives in the same cycle as SPR entry, tick_pending remains set.
- done_redraw:
  - Set the cycle after map_done is sampled in MAP.
  - Cleared the cycle after map_req is sampled low.
  - While set, map_req does not start a new pass. A new pass needs map_req to drop and re-rise.
- Pixel path:
  - vga_* equal the granted requester's inputs one cycle later; vga_plot = registered (granted valid).
  - Valid from an ungranted requester is dropped, with vga_plot=0.
  - A pixel valid in the same cycle as its done pulse is still written.
  - vga_x, vga_y and vga_colour hold their last value when vga_plot=0.
- Timeout counter:
  - Cleared on entry to MAP or SPR; increments each cycle there.
  - Timeout fires when the count reaches TIMEOUT_CYCLES-1 without done. A done in that same cycle counts as normal completion.
  - timeout_err clears only on reset.
- Map priority never preempts an SPR pass in progress.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs map_passes[15:0] and spr_passes[15:0]. These count completed (non-timeout) passes, wrap at 16'hFFFF->0, and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, map_req=1, 5 map pixels at (10,20..24), map_done with the 5th -> grant_map next cycle; 5 vga_plot pulses, each one cycle after its input; done_redraw=1 the cycle after map_done; map_req=0 -> done_redraw=0 next cycle.
- spr_req=1, no frame_tick -> stays IDLE; frame_tick pulse -> grant_spr within 2 cycles; spr_done -> GAP one cycle, then IDLE with grants 0.
- Map pass ends while spr_req=1 and no tick pending -> SPR entered right after GAP (spr_dirty); spr_valid asserted while in MAP -> vga_plot stays 0.
- map_req rises during an SPR pass -> no grant_map until spr_done+GAP; spr_dirty not set by the sprite pass.
- TIMEOUT_CYCLES=16, map_req with no map_done -> abort after 16 MAP cycles; timeout_err=1 sticky; done_redraw stays 0; reset -> timeout_err=0.
- ARB_STATS_EN: 3 map passes and 2 sprite passes -> map_passes=3, spr_passes=2; a timed-out pass does not increment its counter.
